// File: rtl/puf_response_sequencer_if.sv
// Handshake bundle between the wrapper/PUF side (master) and the response sequencer (slave).
interface puf_response_sequencer_if #(
  parameter int NUM_BITS = 8
);
  logic                ena;
  logic                start;
  logic [7:0]          seed;
  logic                puf_bit;
  logic                puf_en;
  logic [7:0]          puf_challenge;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] response;
  logic [NUM_BITS-1:0] unstable;

  modport master (
    output ena, start, seed, puf_bit,
    input  puf_en, puf_challenge, busy, done, response, unstable
  );

  modport slave (
    input  ena, start, seed, puf_bit,
    output puf_en, puf_challenge, busy, done, response, unstable
  );
endinterface

// File: rtl/puf_response_sequencer.sv
// Walks NUM_BITS challenges from a latched seed, majority-votes VOTES samples per
// challenge and publishes a response word plus a non-unanimous-vote mask.
module puf_response_sequencer #(
  parameter int NUM_BITS      = 8,
  parameter int VOTES         = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  puf_response_sequencer_if.slave  bus
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_SAMPLE  = 3'd2;
  localparam logic [2:0] ST_RELAX   = 3'd3;
  localparam logic [2:0] ST_RESOLVE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]          state_q,     state_d;
  logic [7:0]          seed_q,      seed_d;
  logic [7:0]          chal_q,      chal_d;
  logic [BW-1:0]       bit_idx_q,   bit_idx_d;
  logic [CW-1:0]       vote_cnt_q,  vote_cnt_d;
  logic [CW-1:0]       ones_cnt_q,  ones_cnt_d;
  logic [SW-1:0]       settle_q,    settle_d;
  logic [NUM_BITS-1:0] work_resp_q, work_resp_d;
  logic [NUM_BITS-1:0] work_unst_q, work_unst_d;
  logic [NUM_BITS-1:0] resp_q,      resp_d;
  logic [NUM_BITS-1:0] unst_q,      unst_d;
  logic                puf_en_q,    puf_en_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  logic state_busy;
  assign state_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    chal_d      = chal_q;
    bit_idx_d   = bit_idx_q;
    vote_cnt_d  = vote_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    settle_d    = settle_q;
    work_resp_d = work_resp_q;
    work_unst_d = work_unst_q;
    resp_d      = resp_q;
    unst_d      = unst_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ena && bus.start) begin
          state_d     = ST_ARM;
          seed_d      = bus.seed;
          chal_d      = bus.seed;
          bit_idx_d   = '0;
          vote_cnt_d  = '0;
          ones_cnt_d  = '0;
          settle_d    = '0;
          work_resp_d = '0;
          work_unst_d = '0;
        end
      end
      ST_ARM: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        ones_cnt_d = ones_cnt_q + CW'(bus.puf_bit);
        vote_cnt_d = vote_cnt_q + 1'b1;
        state_d    = ST_RELAX;
      end
      ST_RELAX: begin
        state_d = (vote_cnt_q == CW'(VOTES)) ? ST_RESOLVE : ST_ARM;
      end
      ST_RESOLVE: begin
        work_resp_d[bit_idx_q] = (ones_cnt_q > CW'(VOTES / 2));
        work_unst_d[bit_idx_q] = (ones_cnt_q != '0) && (ones_cnt_q != CW'(VOTES));
        vote_cnt_d = '0;
        ones_cnt_d = '0;
        if (bit_idx_q == BW'(NUM_BITS - 1)) begin
          // Publish only complete runs; the working copy already holds this bit.
          resp_d  = work_resp_d;
          unst_d  = work_unst_d;
          state_d = ST_DONE;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          chal_d    = seed_q + 8'(bit_idx_q) + 8'd1;
          state_d   = ST_ARM;
        end
      end
      ST_DONE: begin
        if (!bus.start || !bus.ena) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!bus.ena && state_busy) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are registered, decoded from the state being entered.
  assign puf_en_d = (state_d == ST_ARM) || (state_d == ST_SAMPLE);
  assign busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
  assign done_d   = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      chal_q      <= '0;
      bit_idx_q   <= '0;
      vote_cnt_q  <= '0;
      ones_cnt_q  <= '0;
      settle_q    <= '0;
      work_resp_q <= '0;
      work_unst_q <= '0;
      resp_q      <= '0;
      unst_q      <= '0;
      puf_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      chal_q      <= chal_d;
      bit_idx_q   <= bit_idx_d;
      vote_cnt_q  <= vote_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      settle_q    <= settle_d;
      work_resp_q <= work_resp_d;
      work_unst_q <= work_unst_d;
      resp_q      <= resp_d;
      unst_q      <= unst_d;
      puf_en_q    <= puf_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.puf_en        = puf_en_q;
  assign bus.puf_challenge = chal_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.response      = resp_q;
  assign bus.unstable      = unst_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Directed and randomized runs of the PUF response sequencer against a vote-counting model.
module tb_puf_response_sequencer;

  localparam int NB = 8;
  localparam int NV = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puf_response_sequencer_if #(.NUM_BITS(NB)) intf ();

  puf_response_sequencer #(.NUM_BITS(NB), .VOTES(NV), .SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  // PUF behaviours: 0 const1, 1 challenge lsb, 2 toggle per sample, 3 const0, 4 noise, 5 fixed table
  int   mode = 0;
  logic tog = 1'b1;
  logic noise = 1'b0;
  logic tbl [256];
  int   ones_seen [256];
  logic model_bit;

  always_comb begin
    model_bit = 1'b0;
    case (mode)
      0: model_bit = 1'b1;
      1: model_bit = intf.puf_challenge[0];
      2: model_bit = tog;
      4: model_bit = noise;
      5: model_bit = tbl[intf.puf_challenge];
      default: model_bit = 1'b0;
    endcase
  end
  assign intf.puf_bit = model_bit;

  int checks = 0;
  int fails = 0;

  // Monitor: challenge at each excitation, high-time of each excitation, sample bookkeeping.
  logic [7:0] chal_log [$];
  int         en_runs [$];
  int         en_run = 0;
  logic       prev_en = 1'b0;

  always @(posedge clk) begin
    #1;
    if (intf.puf_en && !prev_en) chal_log.push_back(intf.puf_challenge);
    if (intf.puf_en) begin
      en_run++;
    end else if (prev_en) begin
      en_runs.push_back(en_run);
      en_run = 0;
      if (mode == 2) tog = ~tog;
      if (mode == 4) begin
        ones_seen[intf.puf_challenge] += int'(noise);
        noise = 1'($urandom % 2);
      end
    end
    prev_en = intf.puf_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per bit, count the ones the PUF behaviour delivers over NV samples.
  task automatic model(input logic [7:0] s, input int m, output logic [7:0] er, output logic [7:0] eu);
    er = '0;
    eu = '0;
    for (int i = 0; i < NB; i++) begin
      logic [7:0] c;
      int n;
      c = s + 8'(i);
      n = 0;
      case (m)
        0: n = NV;
        1: n = c[0] ? NV : 0;
        2: for (int k = NV * i; k < NV * (i + 1); k++) n += (k % 2 == 0) ? 1 : 0;
        4: n = ones_seen[c];
        5: n = tbl[c] ? NV : 0;
        default: n = 0;
      endcase
      er[i] = (n > NV / 2);
      eu[i] = (n != 0) && (n != NV);
    end
  endtask

  task automatic do_run(input logic [7:0] s, input int m, input string tag);
    int cyc;
    int bad;
    logic [7:0] er, eu;
    @(negedge clk);
    mode = m;
    tog = 1'b1;
    noise = 1'($urandom % 2);
    for (int c = 0; c < 256; c++) ones_seen[c] = 0;
    chal_log.delete();
    en_runs.delete();
    intf.seed = s;
    intf.start = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check({tag, " busy_after_accept"}, 32'(intf.busy), 32'd1);
      if (intf.done) break;
    end
    check({tag, " latency"}, 32'(cyc), 32'd345);
    intf.seed = ~s;
    model(s, m, er, eu);
    check({tag, " response"}, 32'(intf.response), 32'(er));
    check({tag, " unstable"}, 32'(intf.unstable), 32'(eu));
    check({tag, " busy_in_done"}, 32'(intf.busy), 32'd0);
    check({tag, " excitations"}, 32'(chal_log.size()), 32'(NB * NV));
    bad = 0;
    for (int k = 0; k < chal_log.size(); k++)
      if (chal_log[k] !== s + 8'(k / NV)) bad++;
    check({tag, " challenge_sequence_errors"}, 32'(bad), 32'd0);
    bad = 0;
    foreach (en_runs[k]) if (en_runs[k] != 5) bad++;
    check({tag, " puf_en_highs_not_5"}, 32'(bad), 32'd0);
    // start still high: must stay in DONE, then fall back to IDLE once released.
    @(posedge clk);
    #1;
    check({tag, " done_held"}, 32'(intf.done), 32'd1);
    @(negedge clk);
    intf.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done_cleared"}, 32'(intf.done), 32'd0);
    $display("run %s seed=%02h mode=%0d resp=%02h unst=%02h cycles=%0d", tag, s, m, intf.response, intf.unstable, cyc);
  endtask

  task automatic wait_chal(input logic [7:0] c, input string tag);
    int n;
    n = 0;
    while (intf.puf_challenge !== c && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " reached_challenge"}, 32'(intf.puf_challenge), 32'(c));
  endtask

  initial begin
    intf.ena = 1'b1;
    intf.start = 1'b0;
    intf.seed = 8'h00;
    repeat (2) @(negedge clk);
    check("reset puf_en", 32'(intf.puf_en), 32'd0);
    check("reset busy", 32'(intf.busy), 32'd0);
    check("reset done", 32'(intf.done), 32'd0);
    check("reset challenge", 32'(intf.puf_challenge), 32'd0);
    check("reset response", 32'(intf.response), 32'd0);
    rst_n = 1'b1;

    do_run(8'h00, 0, "const1");
    do_run(8'h00, 1, "chal_lsb");
    do_run(8'h00, 2, "toggle");
    do_run(8'hFE, 1, "wrap");
    for (int r = 0; r < 2; r++) do_run(8'($urandom), 4, "noise");
    for (int c = 0; c < 256; c++) tbl[c] = 1'($urandom % 2);
    for (int r = 0; r < 2; r++) do_run(8'($urandom), 5, "table");

    // Abort: complete with all ones, then drop ena during bit 3 of an all-zeros run.
    do_run(8'h00, 0, "pre_abort");
    @(negedge clk);
    mode = 3;
    intf.seed = 8'h00;
    intf.start = 1'b1;
    wait_chal(8'h03, "abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    intf.ena = 1'b0;
    @(posedge clk);
    #1;
    check("abort puf_en", 32'(intf.puf_en), 32'd0);
    check("abort busy", 32'(intf.busy), 32'd0);
    check("abort done", 32'(intf.done), 32'd0);
    check("abort response_kept", 32'(intf.response), 32'hFF);
    check("abort unstable_kept", 32'(intf.unstable), 32'h00);
    $display("abort resp=%02h busy=%0d", intf.response, intf.busy);
    @(negedge clk);
    intf.start = 1'b0;
    intf.ena = 1'b1;

    // Reset asserted while the DUT is in SAMPLE (5th cycle of an excitation).
    @(negedge clk);
    mode = 1;
    intf.seed = 8'h10;
    intf.start = 1'b1;
    wait_chal(8'h12, "rst");
    while (!intf.puf_en) begin @(posedge clk); #1; end
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst puf_en", 32'(intf.puf_en), 32'd0);
    check("rst busy", 32'(intf.busy), 32'd0);
    check("rst done", 32'(intf.done), 32'd0);
    check("rst challenge", 32'(intf.puf_challenge), 32'd0);
    check("rst response", 32'(intf.response), 32'd0);
    check("rst unstable", 32'(intf.unstable), 32'd0);
    $display("reset mid-run resp=%02h", intf.response);
    intf.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_run(8'h10, 1, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/puf_response_sequencer.md
Name: puf_response_sequencer

Overview:
- Controller sitting between the Tiny Tapeout top-level wrapper and the one-bit PUF cell.
- Walks a run of NUM_BITS challenges derived from a seed. For each challenge it excites the PUF VOTES times, samples the bit and majority-votes the samples.
- Assembles the results into a response word plus a per-bit instability mask.
- The mask flags challenges whose votes were not unanimous, which helps the host pick reliable bits.

Parameters:
- NUM_BITS, 8: response bits per run; range 1..16.
- VOTES, 7: samples per challenge; must be odd, >=1.
- SETTLE_CYCLES, 4: cycles puf_en stays high before each sample; >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable from the wrapper; low aborts any run
- start  in  1  level; sampled only in IDLE
- seed  in  8  base challenge; bit i uses challenge (seed + i) mod 256
- puf_bit  in  1  raw PUF output
- puf_en  out  1  PUF excitation enable
- puf_challenge  out  8  challenge presented to the PUF
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- response  out  NUM_BITS  last completed majority result; response[i] belongs to challenge seed+i
- unstable  out  NUM_BITS  last completed mask; unstable[i]=1 if the votes for bit i were not unanimous

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - puf_en, busy, done, puf_challenge, response, unstable, all counters and the working registers are 0.
- FSM states: IDLE, ARM, SAMPLE, RELAX, RESOLVE, DONE. All outputs are registered.
- IDLE:
  - If ena & start: latch seed, bit_idx=0, vote_cnt=0, ones_cnt=0, clear the working registers, and go to ARM.
  - puf_challenge=seed is driven on the same edge.
- ARM:
  - puf_en=1 for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle, puf_en=1):
  - Capture puf_bit.
  - ones_cnt += puf_bit; vote_cnt += 1.
  - Go to RELAX.
- RELAX (1 cycle, puf_en=0):
  - If vote_cnt==VOTES, go to RESOLVE; otherwise go to ARM.
- RESOLVE (1 cycle, puf_en=0):
  - work_resp[bit_idx] = (ones_cnt > VOTES/2).
  - work_unst[bit_idx] = (ones_cnt != 0 && ones_cnt != VOTES).
  - Clear vote_cnt and ones_cnt.
  - If bit_idx==NUM_BITS-1: copy work_resp/work_unst to response/unstable and go to DONE.
  - Otherwise: bit_idx+=1, puf_challenge = seed+bit_idx+1 (8-bit wrap), and go to ARM.
- DONE:
  - done=1 and busy=0.
  - Leave for IDLE when start==0 or ena==0.
  - start held high therefore does not retrigger.
- Latency:
  - One vote = SETTLE_CYCLES+2 cycles.
  - start accepted -> done high takes NUM_BITS*(VOTES*(SETTLE_CYCLES+2)+1)+1 cycles. With defaults this is 345.
- Counter widths:
  - vote_cnt and ones_cnt are clog2(VOTES+1) bits and never wrap.
  - bit_idx is clog2(NUM_BITS) bits (minimum 1 bit).
- Abort:
  - ena=0 in any busy state forces IDLE at the next edge, with puf_en=0, busy=0 and done=0.
  - response and unstable keep their previous completed values; a partial run is never published.
- start while busy: ignored.
- Reset mid-run: immediate return to reset values; response is cleared.
- seed changes while busy: no effect, because seed was latched at acceptance.
- Challenge overflow: seed=0xFE with NUM_BITS=4 gives challenges 0xFE, 0xFF, 0x00, 0x01.

Test Plan:
- puf_bit tied 1, seed=0x00, defaults:
  - done rises 345 cycles after start accepted.
  - response=0xFF, unstable=0x00.
  - puf_en high-time per vote is exactly 5 cycles (4 ARM + 1 SAMPLE), then 1 low cycle.
- PUF model returns puf_challenge[0], seed=0x00:
  - response=0xAA, unstable=0x00.
  - puf_challenge steps 0x00 through 0x07.
- PUF model toggles on every SAMPLE pulse, starting at 1:
  - Bit i gets 4 ones when i is even and 3 when i is odd.
  - response=0x55, unstable=0xFF.
- seed=0xFE with puf_bit=puf_challenge[0]:
  - Challenges seen are 0xFE, 0xFF, 0x00 … 0x05 in order.
  - response=0xAA.
- Complete a run with puf_bit=1 (response=0xFF). Start a second run with puf_bit=0 and drop ena during bit 3:
  - IDLE is reached next cycle with puf_en=0.
  - response is still 0xFF.
- Async reset pulse mid-SAMPLE:
  - All outputs read 0 while rst_n is low.
  - A new start after release completes normally with the correct response.
